matmul_sequencer: RTL and testbench

Sequencer that drives one run of the systolic matrix_multiplier array. On a start pulse it reads an N x N operand pair, element by element, from two synchronous-read operand memories (A and B). It streams each pair into the array over the in_stb/in_ack handshake, then drains N*N results over the out_stb/out_ack handshake. It sits between the operand buffers and the array and signals completion to the host controller.

---
 rtl/matmul_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Drives one run of the systolic matrix multiplier: fetch A/B pairs, feed the array, drain N*N results.
// Optional stall counter on perf_stall is enabled by defining MMSEQ_PERF_EN.
module matmul_sequencer #(
  parameter int LOG_SIZE = 1,
  parameter int DATA_W   = 32,
  localparam int ADDR_W  = 2 * LOG_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic [DATA_W-1:0] mm_a,
  output logic [DATA_W-1:0] mm_b,
  output logic              mm_in_stb,
  input  logic              mm_in_ack,
  input  logic              mm_out_stb,
  output logic              mm_out_ack,
  output logic [ADDR_W:0]   res_count,
  output logic [31:0]       perf_stall
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT_RD = 3'd2,
    FEED    = 3'd3,
    DRAIN   = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   RES_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   RES_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_d, state_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;
  logic                rd_en_d, rd_en_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [DATA_W-1:0]   mm_a_d, mm_a_q;
  logic [DATA_W-1:0]   mm_b_d, mm_b_q;
  logic                in_stb_d, in_stb_q;
  logic                out_ack_d, out_ack_q;
  logic [ADDR_W-1:0]   idx_d, idx_q;
  logic [ADDR_W:0]     res_d, res_q;
  logic [ADDR_W:0]     res_inc_s;

  // Next-state and registered-output computation for the run sequence.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    mm_a_d    = mm_a_q;
    mm_b_d    = mm_b_q;
    in_stb_d  = in_stb_q;
    out_ack_d = out_ack_q;
    idx_d     = idx_q;
    res_d     = res_q;
    res_inc_s = res_q + RES_ONE;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          idx_d   = {ADDR_W{1'b0}};
          res_d   = {(ADDR_W+1){1'b0}};
          rd_en_d = 1'b1;
          addr_d  = {ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        mm_a_d   = a_rd_data;
        mm_b_d   = b_rd_data;
        in_stb_d = 1'b1;
        state_d  = FEED;
      end
      FEED: begin
        if (in_stb_q && mm_in_ack) begin
          in_stb_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            out_ack_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            addr_d  = idx_q + IDX_ONE;
            rd_en_d = 1'b1;
            state_d = FETCH;
          end
        end else begin
          state_d = FEED;
        end
      end
      DRAIN: begin
        if (out_ack_q && mm_out_stb) begin
          res_d = res_inc_s;
          if (res_inc_s == RES_FULL) begin
            out_ack_d = 1'b0;
            done_d    = 1'b1;
            state_d   = FIN;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        in_stb_d  = 1'b0;
        out_ack_d = 1'b0;
      end
    endcase
  end

  // Sequence state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      mm_a_q    <= {DATA_W{1'b0}};
      mm_b_q    <= {DATA_W{1'b0}};
      in_stb_q  <= 1'b0;
      out_ack_q <= 1'b0;
      idx_q     <= {ADDR_W{1'b0}};
      res_q     <= {(ADDR_W+1){1'b0}};
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      mm_a_q    <= mm_a_d;
      mm_b_q    <= mm_b_d;
      in_stb_q  <= in_stb_d;
      out_ack_q <= out_ack_d;
      idx_q     <= idx_d;
      res_q     <= res_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign a_rd_en    = rd_en_q;
  assign b_rd_en    = rd_en_q;
  assign a_rd_addr  = addr_q;
  assign b_rd_addr  = addr_q;
  assign mm_a       = mm_a_q;
  assign mm_b       = mm_b_q;
  assign mm_in_stb  = in_stb_q;
  assign mm_out_ack = out_ack_q;
  assign res_count  = res_q;

`ifdef MMSEQ_PERF_EN
  logic [31:0] perf_d, perf_q;

  // Stall accounting: array back-pressure on feed, or waiting on results while draining.
  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && start) begin
      perf_d = 32'd0;
    end else if (((in_stb_q && !mm_in_ack) || (state_q == DRAIN && !mm_out_stb)) &&
                 (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: transaction-level model plus directed literal checks.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- DUT 1: LOG_SIZE=1 ----------------
  logic        rst1, start1, busy1, done1, a_en1, b_en1, in_stb1, in_ack1, out_stb1, out_ack1;
  logic [1:0]  a_addr1, b_addr1;
  logic [31:0] a_data1, b_data1, mm_a1, mm_b1, perf1;
  logic [2:0]  res1;
  logic [31:0] mem_a1 [4];
  logic [31:0] mem_b1 [4];

  matmul_sequencer #(.LOG_SIZE(1), .DATA_W(32)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .a_rd_en(a_en1), .a_rd_addr(a_addr1), .a_rd_data(a_data1),
    .b_rd_en(b_en1), .b_rd_addr(b_addr1), .b_rd_data(b_data1),
    .mm_a(mm_a1), .mm_b(mm_b1), .mm_in_stb(in_stb1), .mm_in_ack(in_ack1),
    .mm_out_stb(out_stb1), .mm_out_ack(out_ack1), .res_count(res1), .perf_stall(perf1)
  );

  always @(posedge clk) begin
    if (a_en1) a_data1 <= mem_a1[a_addr1];
    if (b_en1) b_data1 <= mem_b1[b_addr1];
  end

  // ---------------- DUT 2: LOG_SIZE=2 ----------------
  logic        rst2, start2, busy2, done2, a_en2, b_en2, in_stb2, in_ack2, out_stb2, out_ack2;
  logic [3:0]  a_addr2, b_addr2;
  logic [31:0] a_data2, b_data2, mm_a2, mm_b2, perf2;
  logic [4:0]  res2;
  logic [31:0] mem2 [16];
  int          k2 = 0;

  matmul_sequencer #(.LOG_SIZE(2), .DATA_W(32)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
    .a_rd_en(a_en2), .a_rd_addr(a_addr2), .a_rd_data(a_data2),
    .b_rd_en(b_en2), .b_rd_addr(b_addr2), .b_rd_data(b_data2),
    .mm_a(mm_a2), .mm_b(mm_b2), .mm_in_stb(in_stb2), .mm_in_ack(in_ack2),
    .mm_out_stb(out_stb2), .mm_out_ack(out_ack2), .res_count(res2), .perf_stall(perf2)
  );

  always @(posedge clk) begin
    if (a_en2) a_data2 <= mem2[a_addr2];
    if (b_en2) b_data2 <= mem2[b_addr2];
  end

  // Transfers of DUT 2 must be (k,k) in address order.
  always @(negedge clk) begin
    if (in_stb2 && in_ack2 && !rst2) begin
      check("dut2_pair_a", mm_a2, k2);
      check("dut2_pair_b", mm_b2, k2);
      k2++;
    end
  end

  // ---------------- Transaction model for DUT 1 ----------------
  // Tracks a run by event counts: accepted start, pair transfers, result handshakes.
  bit          e_busy, e_done, e_rden, e_stb, e_oack, chk_en;
  bit          hs_in, hs_out, was_done;
  int          e_addr, e_xfer, e_res, wait_cnt;
  logic [31:0] e_a, e_b;
  longint      e_perf;

  always @(posedge clk) begin
    if (rst1) begin
      e_busy = 0; e_done = 0; e_rden = 0; e_stb = 0; e_oack = 0;
      e_addr = 0; e_xfer = 0; e_res = 0; wait_cnt = 0; e_a = 0; e_b = 0; e_perf = 0;
      chk_en = 1;
    end else begin
      hs_in    = e_stb && in_ack1;
      hs_out   = e_oack && out_stb1;
      was_done = e_done;
      if ((e_stb && !in_ack1) || (e_oack && !out_stb1)) e_perf++;
      e_done = 0;
      e_rden = 0;
      if (wait_cnt != 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          e_stb = 1;
          e_a   = mem_a1[e_xfer];
          e_b   = mem_b1[e_xfer];
        end
      end
      if (hs_in) begin
        e_stb = 0;
        e_xfer++;
        if (e_xfer == 4) e_oack = 1;
        else begin e_rden = 1; e_addr = e_xfer; wait_cnt = 2; end
      end
      if (hs_out) begin
        e_res++;
        if (e_res == 4) begin e_oack = 0; e_done = 1; end
      end
      if (!e_busy && start1) begin
        e_busy = 1; e_xfer = 0; e_res = 0; e_perf = 0;
        e_rden = 1; e_addr = 0; wait_cnt = 2;
      end
      if (was_done) e_busy = 0;
    end
  end

  // Cycle-by-cycle comparison of DUT 1 against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy1, e_busy);
      check("done", done1, e_done);
      check("a_rd_en", a_en1, e_rden);
      check("b_rd_en", b_en1, e_rden);
      if (e_rden) begin
        check("a_rd_addr", a_addr1, e_addr);
        check("b_rd_addr", b_addr1, e_addr);
      end
      check("mm_in_stb", in_stb1, e_stb);
      if (e_stb) begin
        check("mm_a", mm_a1, e_a);
        check("mm_b", mm_b1, e_b);
      end
      check("mm_out_ack", out_ack1, e_oack);
      check("res_count", res1, e_res);
`ifdef MMSEQ_PERF_EN
      check("perf_stall", perf1, e_perf);
`else
      check("perf_stall", perf1, 0);
`endif
    end
  end

  // Record DUT 1 transfers and fetch addresses for literal checks.
  int pa[$], pb[$], pc[$], fa[$];
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (in_stb1 && in_ack1) begin pa.push_back(mm_a1); pb.push_back(mm_b1); pc.push_back(cyc); end
    if (a_en1) fa.push_back(a_addr1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    pa.delete(); pb.delete(); pc.delete(); fa.delete();
  endtask

  task automatic check_pairs(input string tag, input bit check_gap);
    check({tag, "_npairs"}, pa.size(), 4);
    for (int i = 0; i < pa.size() && i < 4; i++) begin
      check({tag, "_pair_a"}, pa[i], i + 1);
      check({tag, "_pair_b"}, pb[i], i + 5);
      if (check_gap && i > 0) check({tag, "_gap"}, pc[i] - pc[i-1], 3);
    end
  endtask

  int res_seq[$];

  // One run: optional DRAIN strobe toggling, early start at cycle n, start on FIN cycle.
  task automatic run1(input bit tog, input int early, input bit fin_start, output int dones);
    bit seen;
    int last;
    dones = 0; seen = 0; last = 0;
    res_seq.delete();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      start1   = (n == early);
      out_stb1 = (tog && e_oack) ? ~out_stb1 : 1'b1;
      if (int'(res1) != last && res1 != 3'd0) begin res_seq.push_back(res1); last = res1; end
      if (done1) begin
        seen = 1; dones++;
        check("done_res_count", res1, 4);
        check("done_out_ack", out_ack1, 0);
        start1 = fin_start;
      end
      tick();
    end
    if (!seen) check("run1_timeout", 0, 1);
    check("busy_after_done", busy1, 0);
    start1 = 1'b0; out_stb1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (done1) dones++;
      tick();
    end
    check("idle_after_run", busy1, 0);
  endtask

  int dones;
  int guard;

  initial begin
    rst1 = 1'b1; start1 = 1'b0; in_ack1 = 1'b1; out_stb1 = 1'b1;
    rst2 = 1'b1; start2 = 1'b0; in_ack2 = 1'b1; out_stb2 = 1'b1;
    for (int i = 0; i < 4; i++) begin mem_a1[i] = i + 1; mem_b1[i] = i + 5; end
    for (int i = 0; i < 16; i++) mem2[i] = i;
    tick(); tick();
    rst1 = 1'b0; rst2 = 1'b0;

    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_rd_en", a_en1, 0);
    check("rst_addr", a_addr1, 0);
    check("rst_stb", in_stb1, 0);
    check("rst_mm_a", mm_a1, 0);
    check("rst_out_ack", out_ack1, 0);
    check("rst_res", res1, 0);
    check("rst_perf", perf1, 0);
    check("rst_busy2", busy2, 0);

    // 1: basic run, acks tied high.
    clear_log();
    run1(1'b0, -1, 1'b0, dones);
    check("t1_dones", dones, 1);
    check_pairs("t1", 1'b1);

    // 2: second element back-pressured for 5 cycles.
    clear_log();
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (guard = 0; guard < 50 && e_xfer != 1; guard++) tick();
    in_ack1 = 1'b0;
    for (guard = 0; guard < 50 && !in_stb1; guard++) tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_stb_held", in_stb1, 1);
      check("t2_a_stable", mm_a1, 2);
      check("t2_b_stable", mm_b1, 6);
      tick();
    end
    in_ack1 = 1'b1;
    for (guard = 0; guard < 100 && !done1; guard++) tick();
    check("t2_done_seen", done1, 1);
`ifdef MMSEQ_PERF_EN
    check("t2_perf", perf1, 5);
`else
    check("t2_perf", perf1, 0);
`endif
    tick(); tick();
    check_pairs("t2", 1'b0);

    // 3: result strobe every other cycle.
    run1(1'b1, -1, 1'b0, dones);
    check("t3_dones", dones, 1);
    check("t3_res_steps", res_seq.size(), 4);
    for (int i = 0; i < res_seq.size() && i < 4; i++) check("t3_res_step", res_seq[i], i + 1);

    // 4: start while busy and on the FIN cycle is ignored.
    clear_log();
    run1(1'b0, 3, 1'b1, dones);
    check("t4_dones", dones, 1);
    check_pairs("t4", 1'b1);

    // 5: reset during FEED at idx 2, then a clean run from address 0.
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (guard = 0; guard < 50 && e_xfer != 2; guard++) tick();
    in_ack1 = 1'b0;
    for (guard = 0; guard < 50 && !in_stb1; guard++) tick();
    check("t5_feed_a", mm_a1, 3);
    rst1 = 1'b1; tick(); rst1 = 1'b0; in_ack1 = 1'b1;
    check("t5_rst_busy", busy1, 0);
    check("t5_rst_stb", in_stb1, 0);
    check("t5_rst_mm_a", mm_a1, 0);
    check("t5_rst_res", res1, 0);
    check("t5_rst_done", done1, 0);
    check("t5_rst_perf", perf1, 0);
    tick();
    check("t5_no_done", done1, 0);
    clear_log();
    run1(1'b0, -1, 1'b0, dones);
    check("t5_dones", dones, 1);
    check_pairs("t5", 1'b1);
    check("t5_first_addr", (fa.size() > 0) ? fa[0] : -1, 0);

    // 6: LOG_SIZE=2, memory = address.
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (guard = 0; guard < 400 && !done2; guard++) tick();
    check("t6_done_seen", done2, 1);
    check("t6_res_count", res2, 16);
    check("t6_pairs", k2, 16);
    tick();
    check("t6_busy_after", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
